data_mem_ctrl: RTL
==================

// Module: data_mem_ctrl
// PURPOSE
//  Data-memory controller between the 16-bit micro CPU load/store port and an external
//  word-wide SRAM with variable ack latency. Stalls the CPU until each access completes.
//  Decodes one memory-mapped I/O word: an output latch and a sampled input.
//  Aborts hung SRAM accesses on timeout.
// PARAMETERS
//  ADDR_W      12      CPU/SRAM word address width
//  DATA_W      16      data width
//  IO_ADDR     12'hFFF address of the MMIO word (never forwarded to SRAM)
//  TIMEOUT     15      max cycles in REQ waiting for sram_ack before abort
//  ERR_DATA    16'hDEAD read data returned on timeout
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       synchronous, active-high
//  cpu_rd       in   1       load request; held stable while cpu_stall=1
//  cpu_wr       in   1       store request; held stable while cpu_stall=1
//  cpu_addr     in   ADDR_W  word address
//  cpu_wdata    in   DATA_W  store data
//  cpu_rdata    out  DATA_W  load data (registered)
//  cpu_stall    out  1       CPU must hold PC/request while high
//  sram_req     out  1       SRAM request, held until sram_ack
//  sram_we      out  1       1=write, 0=read; valid with sram_req
//  sram_addr    out  ADDR_W  SRAM address (registered)
//  sram_wdata   out  DATA_W  SRAM write data (registered)
//  sram_rdata   in   DATA_W  SRAM read data; valid in the sram_ack cycle
//  sram_ack     in   1       one-cycle completion pulse
//  io_in        in   DATA_W  external input word, read at IO_ADDR
//  io_out       out  DATA_W  output latch, written at IO_ADDR
//  err_timeout  out  1       one-cycle pulse when an SRAM access is aborted
// BEHAVIOUR
//  Reset (sync): state=IDLE; cpu_rdata=0, io_out=0, sram_req=0, sram_we=0,
//   sram_addr=0, sram_wdata=0, err_timeout=0, timeout counter=0.
//   A reset mid-access drops sram_req on that edge; a later sram_ack is ignored.
//  FSM: IDLE, REQ, RESP.
//   IDLE: cpu_wr or cpu_rd seen ->
//    addr==IO_ADDR: wr latches io_out<=cpu_wdata; rd latches cpu_rdata<=io_in; ->RESP.
//    else: latch sram_addr/sram_wdata, sram_we<=cpu_wr, sram_req<=1, cnt<=0; ->REQ.
//   REQ: sram_ack=1 -> sram_req<=0; if read, cpu_rdata<=sram_rdata; ->RESP.
//    else if cnt==TIMEOUT-1 -> sram_req<=0, err_timeout<=1, read gets cpu_rdata<=ERR_DATA;
//     write is dropped; ->RESP. Otherwise cnt++.
//   RESP: one cycle, ->IDLE unconditionally; new requests are not sampled in RESP.
//  cpu_stall (combinational) = (IDLE & (cpu_rd|cpu_wr)) | REQ; it is 0 in RESP.
//  The CPU advances on the RESP edge.
//  Latency: MMIO has 1 stall cycle. SRAM has k+1 stall cycles, where the ack arrives
//   k cycles after sram_req rises (k>=1).
//  cpu_rd & cpu_wr both high: the write is performed and the read is ignored.
//  cpu_rdata holds its value until the next completed load; writes never change it.
//  sram_ack outside REQ is ignored.
//  An ack in the same cycle as timeout expiry counts as success (ack has priority).
//  sram_addr/sram_wdata are stable for the whole REQ phase.
// STRUCTURE
//  Shared package (mem_pkg): state encoding constants (IDLE/REQ/RESP), IO_ADDR,
//   ERR_DATA, ADDR_W/DATA_W defaults.
//  One sub-module: timeout_counter (clear, enable, terminal count at TIMEOUT-1).
//  The remaining logic (FSM, MMIO latch, SRAM regs) lives flat in data_mem_ctrl.
// TESTING
//  1. SRAM model acks 2 cycles after req; rd addr 12'h010, sram_rdata=16'h1234
//     -> cpu_stall high 3 cycles, then cpu_rdata=16'h1234, sram_req low.
//  2. wr addr 12'h020 data 16'hBEEF, ack after 1 cycle
//     -> sram_we=1, sram_addr=12'h020, sram_wdata=16'hBEEF for the whole REQ phase;
//        stall 2 cycles.
//  3. wr IO_ADDR data 16'h00A5, then rd IO_ADDR with io_in=16'h5A5A
//     -> io_out=16'h00A5, cpu_rdata=16'h5A5A, each with 1 stall cycle, sram_req never set.
//  4. rd addr 12'h030, no ack -> after 15 REQ cycles err_timeout pulses once,
//     cpu_rdata=16'hDEAD, FSM back in IDLE.
//  5. Reset asserted 2 cycles into REQ, stray ack 1 cycle later
//     -> all outputs at reset values, state IDLE, the ack causes no cpu_rdata change.
//  6. rd & wr both high at addr 12'h040 -> single SRAM write, cpu_rdata unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory controller: default sizes, the MMIO
// address, the abort read value and the FSM state encoding.
package mem_pkg;

  localparam int          ADDR_W_DEF   = 12;
  localparam int          DATA_W_DEF   = 16;
  localparam int          TIMEOUT_DEF  = 15;
  localparam logic [11:0] IO_ADDR_DEF  = 12'hFFF;
  localparam logic [15:0] ERR_DATA_DEF = 16'hDEAD;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/data_mem_ctrl_timeout_counter.sv
// Cycle counter for the SRAM wait phase; tc flags the last cycle the
// controller is willing to wait for an acknowledge.
module timeout_counter #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store port controller: stalls the CPU across SRAM accesses, decodes a
// single MMIO word and aborts SRAM accesses that never acknowledge.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for cpu_rd/cpu_wr; MMIO handled here in one edge
// REQ     | sram_req held, waiting for sram_ack or the timeout
// RESP    | access done, stall released, CPU advances on this edge
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] IO_ADDR  = IO_ADDR_DEF,
  parameter int                TIMEOUT  = TIMEOUT_DEF,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              sram_req,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_ack,
  input  logic [DATA_W-1:0] io_in,
  output logic [DATA_W-1:0] io_out,
  output logic              err_timeout
);

  state_t state, state_nxt;
  logic   req_seen;
  logic   is_io;
  logic   tc;

  assign req_seen  = cpu_rd | cpu_wr;
  assign is_io     = (cpu_addr == IO_ADDR);
  assign cpu_stall = ((state == ST_IDLE) && req_seen) || (state == ST_REQ);

  timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != ST_REQ),
    .enable (state == ST_REQ),
    .tc     (tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (req_seen) state_nxt = is_io ? ST_RESP : ST_REQ;
      ST_REQ:  if (sram_ack || tc) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A simultaneous read+write is treated as a write; the read half is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rdata   <= '0;
      io_out      <= '0;
      sram_req    <= 1'b0;
      sram_we     <= 1'b0;
      sram_addr   <= '0;
      sram_wdata  <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req_seen) begin
            if (is_io) begin
              if (cpu_wr) io_out <= cpu_wdata;
              else        cpu_rdata <= io_in;
            end else begin
              sram_addr  <= cpu_addr;
              sram_wdata <= cpu_wdata;
              sram_we    <= cpu_wr;
              sram_req   <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          // Ack wins over an expiring timeout in the same cycle.
          if (sram_ack) begin
            sram_req <= 1'b0;
            if (!sram_we) cpu_rdata <= sram_rdata;
          end else if (tc) begin
            sram_req    <= 1'b0;
            err_timeout <= 1'b1;
            if (!sram_we) cpu_rdata <= ERR_DATA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
